// File: rtl/my_nios2_system_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the OCIMEM debug/CPU arbiter.
package my_nios2_system_cpu_ocimem_pkg;

    typedef enum logic [1:0] {StIdle, StDbgAcc, StCpuAcc} state_e;
    typedef enum logic [1:0] {CmdNone, CmdRd, CmdWr} cmd_e;
    typedef enum logic {OwnDbg, OwnCpu} owner_e;

    localparam int unsigned JDO_ADDR_LSB  = 26;
    localparam int unsigned JDO_WDATA_LSB = 3;
    localparam int unsigned JDO_WDATA_MSB = 34;

    localparam int unsigned TimeoutW = 16;

endpackage

// File: rtl/my_nios2_system_cpu_ocimem_timeout.sv
// Loadable down-counter; expired_o flags that the loaded budget has run out.
module my_nios2_system_cpu_ocimem_timeout #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/my_nios2_system_cpu_ocimem_arb.sv
// Arbitrates JTAG OCIMEM debug commands against CPU accesses to the debug RAM.
// Define OCIMEM_DEBUG_LOCKOUT_EN to block CPU grants while debugack is high.
module my_nios2_system_cpu_ocimem_arb
    import my_nios2_system_cpu_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic              debugack,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [TimeoutW-1:0] TmoLoad = TimeoutW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    owner_e            last_q, last_d;
    cmd_e              cmd_q, cmd_d;
    logic              pending_q, pending_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic              defer_q, defer_d;
    logic [ADDR_W-1:0] defer_addr_q, defer_addr_d;
    logic [31:0]       mon_q, mon_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              stb_a, stb_b, stb_r, cpu_ok, acc_done, tmo_load, tmo_expired;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_wdata;
    logic              unused_jdo;

    assign stb_a     = take_action_ocimem_a;
    assign stb_b     = take_action_ocimem_b & ~take_action_ocimem_a;
    assign stb_r     = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign unused_jdo = ^jdo;

`ifdef OCIMEM_DEBUG_LOCKOUT_EN
    assign cpu_ok = cpu_req & ~debugack;
`else
    logic unused_debugack;
    assign unused_debugack = debugack;
    assign cpu_ok = cpu_req;
`endif

    assign mem_en   = (state_q != StIdle);
    assign acc_done = mem_en && (mem_ack || tmo_expired);

    my_nios2_system_cpu_ocimem_timeout #(
        .Width (TimeoutW)
    ) u_timeout (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmo_load),
        .load_val_i (TmoLoad),
        .en_i       (mem_en),
        .expired_o  (tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cmd_d        = cmd_q;
        pending_d    = pending_q;
        wdata_d      = wdata_q;
        dbg_addr_d   = dbg_addr_q;
        defer_d      = defer_q;
        defer_addr_d = defer_addr_q;
        mon_d        = mon_q;
        err_d        = err_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tmo_load     = 1'b0;
        cpu_gnt      = 1'b0;
        cpu_rvalid   = 1'b0;
        cpu_rdata    = '0;

        // An address load during an in-flight command is parked until it completes.
        if (stb_a) begin
            err_d = 1'b0;
            if (pending_q) begin
                defer_d      = 1'b1;
                defer_addr_d = jdo_addr;
            end else begin
                dbg_addr_d = jdo_addr;
            end
        end else if (stb_b || stb_r) begin
            if (pending_q) begin
                err_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                cmd_d     = stb_b ? CmdWr : CmdRd;
                if (stb_b) begin
                    wdata_d = jdo_wdata;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (pending_q && (!cpu_ok || last_q == OwnCpu)) begin
                    state_d     = StDbgAcc;
                    tmo_load    = 1'b1;
                    mem_addr_d  = dbg_addr_q;
                    mem_we_d    = (cmd_q == CmdWr);
                    mem_wdata_d = wdata_q;
                end else if (cpu_ok) begin
                    state_d     = StCpuAcc;
                    tmo_load    = 1'b1;
                    mem_addr_d  = cpu_addr;
                    mem_we_d    = cpu_we;
                    mem_wdata_d = cpu_wdata;
                end
            end
            StDbgAcc: begin
                if (acc_done) begin
                    state_d   = StIdle;
                    mem_we_d  = 1'b0;
                    last_d    = OwnDbg;
                    pending_d = 1'b0;
                    defer_d   = 1'b0;
                    if (mem_ack) begin
                        if (cmd_q == CmdRd) begin
                            mon_d = mem_rdata;
                        end
                        dbg_addr_d = dbg_addr_q + ADDR_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (stb_a) begin
                        dbg_addr_d = jdo_addr;
                    end else if (defer_q) begin
                        dbg_addr_d = defer_addr_q;
                    end
                end
            end
            StCpuAcc: begin
                if (acc_done) begin
                    state_d  = StIdle;
                    mem_we_d = 1'b0;
                    last_d   = OwnCpu;
                    cpu_gnt  = 1'b1;
                    if (mem_ack && !mem_we_q) begin
                        cpu_rvalid = 1'b1;
                        cpu_rdata  = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_q       <= OwnCpu;
            cmd_q        <= CmdNone;
            pending_q    <= 1'b0;
            wdata_q      <= '0;
            dbg_addr_q   <= '0;
            defer_q      <= 1'b0;
            defer_addr_q <= '0;
            mon_q        <= '0;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cmd_q        <= cmd_d;
            pending_q    <= pending_d;
            wdata_q      <= wdata_d;
            dbg_addr_q   <= dbg_addr_d;
            defer_q      <= defer_d;
            defer_addr_q <= defer_addr_d;
            mon_q        <= mon_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign MonDReg       = mon_q;
    assign monitor_ready = ~pending_q;
    assign monitor_error = err_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_my_nios2_system_cpu_ocimem_arb.sv
// Directed bench for the OCIMEM arbiter: debug reads/writes, round-robin, overrun, timeout, reset.
module tb_my_nios2_system_cpu_ocimem_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic        debugack;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_gnt, cpu_rvalid;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    logic [31:0] ram [256];
    logic        ram_on;
    logic        ram_ack_q = 1'b0;
    logic        stale_ack;
    int          n_checks = 0;
    int          n_errs = 0;
    int          gnt_cnt = 0;
    logic [7:0]  log_addr [$];
    logic        log_we [$];
    logic [31:0] log_wd [$];
    logic        log_cpu [$];

    my_nios2_system_cpu_ocimem_arb #(
        .ADDR_W  (8),
        .TIMEOUT (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .debugack                (debugack),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_req                 (cpu_req),
        .cpu_we                  (cpu_we),
        .cpu_addr                (cpu_addr),
        .cpu_wdata               (cpu_wdata),
        .cpu_gnt                 (cpu_gnt),
        .cpu_rvalid              (cpu_rvalid),
        .cpu_rdata               (cpu_rdata),
        .mem_en                  (mem_en),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .mem_ack                 (mem_ack)
    );

    always #5 clk = ~clk;

    // RAM answers in the second cycle of mem_en; writes are only logged, never stored.
    always @(posedge clk) begin
        if (mem_en && ram_on && !ram_ack_q) begin
            ram_ack_q <= 1'b1;
            mem_rdata <= ram[mem_addr];
        end else begin
            ram_ack_q <= 1'b0;
        end
    end
    assign mem_ack = ram_ack_q | stale_ack;

    always @(posedge clk) begin
        if (mem_en && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wd.push_back(mem_wdata);
            log_cpu.push_back(cpu_gnt);
        end
        if (cpu_gnt) gnt_cnt <= gnt_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [7:0] addr);
        jdo = 38'(addr) << 26;
        take_action_ocimem_a = 1'b1;
        tick(1);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_wr(input logic [31:0] data);
        jdo = 38'(data) << 3;
        take_action_ocimem_b = 1'b1;
        tick(1);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_rd();
        take_no_action_ocimem_a = 1'b1;
        tick(1);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!monitor_ready && n < 50) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(monitor_ready), 32'd1);
    endtask

    task automatic cpu_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            output logic seen, output logic rv, output logic [31:0] rd);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        seen = 1'b0;
        rv = 1'b0;
        rd = '0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick(1);
            if (cpu_gnt) begin
                seen = 1'b1;
                rv = cpu_rvalid;
                rd = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        tick(1);
    endtask

    logic        seen, rv, got;
    logic [31:0] rd;
    int          base, en_cnt, g0;

    initial begin
        take_action_ocimem_a = 0;
        take_action_ocimem_b = 0;
        take_no_action_ocimem_a = 0;
        jdo = '0;
        debugack = 0;
        cpu_req = 0;
        cpu_we = 0;
        cpu_addr = '0;
        cpu_wdata = '0;
        ram_on = 1;
        stale_ack = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | 32'(i);
        ram[8'h10] = 32'h11;
        ram[8'h11] = 32'h22;
        ram[8'h12] = 32'h33;
        ram[8'h00] = 32'h5A5A;
        ram[8'h20] = 32'hDEAD_0020;

        tick(3);
        check_eq("rst_mondreg", MonDReg, 32'h0);
        check_eq("rst_ready", 32'(monitor_ready), 32'd1);
        check_eq("rst_error", 32'(monitor_error), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
        reset = 0;
        tick(1);

        // Sequential debug reads with auto-increment.
        strobe_a(8'h10);
        for (int i = 0; i < 3; i++) begin
            strobe_rd();
            check_eq("rd_busy", 32'(monitor_ready), 32'd0);
            wait_ready("rd_ready");
            check_eq("rd_data", MonDReg, 32'h11 * 32'(i + 1));
            check_eq("rd_addr", 32'(log_addr[log_addr.size()-1]), 32'h10 + 32'(i));
        end

        // Write at the top address, then a read wraps to zero.
        strobe_a(8'hFF);
        strobe_wr(32'hCAFE_F00D);
        wait_ready("wr_ready");
        check_eq("wr_addr", 32'(log_addr[log_addr.size()-1]), 32'hFF);
        check_eq("wr_we", 32'(log_we[log_we.size()-1]), 32'd1);
        check_eq("wr_data", log_wd[log_wd.size()-1], 32'hCAFE_F00D);
        strobe_rd();
        wait_ready("wrap_ready");
        check_eq("wrap_addr", 32'(log_addr[log_addr.size()-1]), 32'h00);
        check_eq("wrap_data", MonDReg, 32'h5A5A);

        // CPU read leaves last_grant on the CPU side.
        cpu_xfer(1'b0, 8'h20, 32'h0, seen, rv, rd);
        check_eq("cpu_gnt_seen", 32'(seen), 32'd1);
        check_eq("cpu_rvalid", 32'(rv), 32'd1);
        check_eq("cpu_rdata", rd, 32'hDEAD_0020);

        // Five debug/CPU pairs contending: debug first each time, then CPU.
        for (int i = 0; i < 5; i++) begin
            base = log_cpu.size();
            g0 = gnt_cnt;
            strobe_rd();
            cpu_req = 1'b1;
            cpu_we = 1'b0;
            cpu_addr = 8'h30;
            got = 1'b0;
            for (int n = 0; n < 60 && !(got && monitor_ready); n++) begin
                tick(1);
                if (cpu_gnt) begin
                    got = 1'b1;
                    cpu_req = 1'b0;
                end
            end
            tick(1);
            check_eq("rr_cpu_served", 32'(got), 32'd1);
            check_eq("rr_count", 32'(log_cpu.size() - base), 32'd2);
            check_eq("rr_first_dbg", 32'(log_cpu[base]), 32'd0);
            check_eq("rr_second_cpu", 32'(log_cpu[base+1]), 32'd1);
            check_eq("rr_dbg_addr", 32'(log_addr[base]), 32'd1 + 32'(i));
            check_eq("rr_gnt_once", 32'(gnt_cnt - g0), 32'd1);
        end

        // Overrun: a second read while the first is in flight.
        strobe_a(8'h60);
        base = log_addr.size();
        strobe_rd();
        strobe_rd();
        check_eq("ovr_error", 32'(monitor_error), 32'd1);
        wait_ready("ovr_ready");
        tick(3);
        check_eq("ovr_one_access", 32'(log_addr.size() - base), 32'd1);
        check_eq("ovr_data", MonDReg, 32'hA000_0060);
        check_eq("ovr_sticky", 32'(monitor_error), 32'd1);
        strobe_a(8'h40);
        check_eq("ovr_cleared", 32'(monitor_error), 32'd0);

        // Debug timeout: no ack, mem_en held exactly TIMEOUT cycles.
        ram_on = 0;
        strobe_rd();
        en_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick(1);
            if (mem_en) en_cnt++;
        end
        check_eq("tmo_en_cycles", 32'(en_cnt), 32'd8);
        check_eq("tmo_error", 32'(monitor_error), 32'd1);
        check_eq("tmo_ready", 32'(monitor_ready), 32'd1);
        check_eq("tmo_mondreg", MonDReg, 32'hA000_0060);
        ram_on = 1;
        strobe_rd();
        wait_ready("tmo_retry_ready");
        check_eq("tmo_no_incr", 32'(log_addr[log_addr.size()-1]), 32'h40);
        check_eq("tmo_retry_data", MonDReg, 32'hA000_0040);

        // CPU timeout.
        ram_on = 0;
        cpu_xfer(1'b0, 8'h22, 32'h0, seen, rv, rd);
        check_eq("ctmo_gnt", 32'(seen), 32'd1);
        check_eq("ctmo_rvalid", 32'(rv), 32'd0);
        check_eq("ctmo_rdata", rd, 32'h0);

        // Reset during a debug access, then a stale ack.
        strobe_a(8'h50);
        strobe_rd();
        tick(2);
        check_eq("mid_mem_en", 32'(mem_en), 32'd1);
        reset = 1;
        tick(1);
        check_eq("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("mid_rst_ready", 32'(monitor_ready), 32'd1);
        reset = 0;
        base = log_addr.size();
        stale_ack = 1;
        tick(1);
        stale_ack = 0;
        tick(1);
        check_eq("stale_mem_en", 32'(mem_en), 32'd0);
        check_eq("stale_ready", 32'(monitor_ready), 32'd1);
        check_eq("stale_no_access", 32'(log_addr.size() - base), 32'd0);
        check_eq("stale_mondreg", MonDReg, 32'h0);
        ram_on = 1;
        strobe_rd();
        wait_ready("post_rst_ready");
        check_eq("post_rst_addr", 32'(log_addr[log_addr.size()-1]), 32'h00);
        check_eq("post_rst_data", MonDReg, 32'h5A5A);

`ifdef OCIMEM_DEBUG_LOCKOUT_EN
        // CPU held off across 20 debug commands while debugack is high.
        debugack = 1;
        cpu_req = 1;
        cpu_we = 0;
        cpu_addr = 8'h31;
        g0 = gnt_cnt;
        for (int i = 0; i < 20; i++) begin
            strobe_rd();
            wait_ready("lock_ready");
            tick(1);
        end
        check_eq("lock_no_cpu_gnt", 32'(gnt_cnt - g0), 32'd0);
        debugack = 0;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            tick(1);
            if (cpu_gnt) begin
                got = 1'b1;
                cpu_req = 1'b0;
            end
        end
        check_eq("lock_release_gnt", 32'(got), 32'd1);
        cpu_req = 0;
        tick(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
